branch_unit_4way: RTL and testbench

Resolves branch and jump instructions for the 4-thread fine-grained pipeline and drives the redirect interface of the per-thread instruction pointers (`br_tid`, `br_addr`, `branch`, `en`). Sits at the execute stage. It evaluates the branch condition on the forwarded operands and registers the redirect for the fetch side. It also tracks, per thread, how many wrong-path instructions are still in flight, so execute can kill them before writeback.

---
 rtl/branch_unit_4way.sv | 137 +++++++++++++
 tb/tb_branch_unit_4way.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_4way.sv
// branch_unit_4way: execute-stage branch resolution for a 4-thread
// fine-grained pipeline. Evaluates branch conditions on forwarded operands,
// registers the fetch redirect, counts taken branches and tracks per-thread
// wrong-path instructions still in flight so they can be killed.
module branch_unit_4way #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int SQUASH_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ex_valid,
  input  logic [1:0]        ex_tid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              ex_kill,
  output logic              branch,
  output logic [1:0]        br_tid,
  output logic [ADDR_W-1:0] br_addr,
  output logic [15:0]       br_count
);

  localparam int SQ_W = $clog2(SQUASH_DEPTH + 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_DEPTH);
  localparam logic [SQ_W-1:0] SQ_ZERO = {SQ_W{1'b0}};
  localparam logic [SQ_W-1:0] SQ_ONE  = {{(SQ_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_BEQ = 3'd0;
  localparam logic [2:0] OP_BNE = 3'd1;
  localparam logic [2:0] OP_BLT = 3'd2;
  localparam logic [2:0] OP_BGE = 3'd3;
  localparam logic [2:0] OP_J   = 3'd4;
  localparam logic [2:0] OP_JR  = 3'd5;

  logic [SQ_W-1:0]   sq_q [4];
  logic [SQ_W-1:0]   sq_d [4];
  logic              branch_q, branch_d;
  logic [1:0]        br_tid_q, br_tid_d;
  logic [ADDR_W-1:0] br_addr_q, br_addr_d;
  logic [15:0]       br_count_q, br_count_d;

  logic              taken_s;
  logic [ADDR_W-1:0] target_s;

  // Wrong-path detection: the thread still has squash credits outstanding.
  always_comb begin
    ex_kill = ex_valid && (sq_q[ex_tid] != SQ_ZERO);
  end

  // Branch condition and target selection; killed instructions never resolve.
  always_comb begin
    taken_s  = 1'b0;
    target_s = ex_target;
    if (ex_valid && !ex_kill) begin
      case (ex_op)
        OP_BEQ:  taken_s = (ex_rs == ex_rt);
        OP_BNE:  taken_s = (ex_rs != ex_rt);
        OP_BLT:  taken_s = ($signed(ex_rs) <  $signed(ex_rt));
        OP_BGE:  taken_s = ($signed(ex_rs) >= $signed(ex_rt));
        OP_J:    taken_s = 1'b1;
        OP_JR: begin
          taken_s  = 1'b1;
          target_s = ex_rs[ADDR_W-1:0];
        end
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  // Next-state: redirect, counter and squash credits advance only on en.
  always_comb begin
    branch_d   = branch_q;
    br_tid_d   = br_tid_q;
    br_addr_d  = br_addr_q;
    br_count_d = br_count_q;
    for (int t = 0; t < 4; t++) begin
      sq_d[t] = sq_q[t];
    end
    if (en) begin
      branch_d = taken_s;
      if (taken_s) begin
        br_tid_d   = ex_tid;
        br_addr_d  = target_s;
        br_count_d = br_count_q + 16'd1;
      end else begin
        br_tid_d   = br_tid_q;
        br_addr_d  = br_addr_q;
        br_count_d = br_count_q;
      end
      // A killed instruction cannot branch, so load and decrement on the
      // same thread are mutually exclusive; other threads are unaffected.
      for (int t = 0; t < 4; t++) begin
        if (taken_s && (ex_tid == 2'(t))) begin
          sq_d[t] = SQ_LOAD;
        end else if (ex_kill && (ex_tid == 2'(t))) begin
          sq_d[t] = sq_q[t] - SQ_ONE;
        end else begin
          sq_d[t] = sq_q[t];
        end
      end
    end else begin
      branch_d = branch_q;
    end
  end

  // State registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q   <= 1'b0;
      br_tid_q   <= 2'd0;
      br_addr_q  <= {ADDR_W{1'b0}};
      br_count_q <= 16'd0;
      for (int t = 0; t < 4; t++) begin
        sq_q[t] <= SQ_ZERO;
      end
    end else begin
      branch_q   <= branch_d;
      br_tid_q   <= br_tid_d;
      br_addr_q  <= br_addr_d;
      br_count_q <= br_count_d;
      for (int t = 0; t < 4; t++) begin
        sq_q[t] <= sq_d[t];
      end
    end
  end

  assign branch   = branch_q;
  assign br_tid   = br_tid_q;
  assign br_addr  = br_addr_q;
  assign br_count = br_count_q;

endmodule

// File: tb/tb_branch_unit_4way.sv
// Testbench for branch_unit_4way: table-driven vectors with hand-derived
// kill/redirect expectations, plus a reference model whose registered
// results go through a scoreboard queue and are compared after each edge.
module tb_branch_unit_4way;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ex_valid;
  logic [1:0]  ex_tid;
  logic [2:0]  ex_op;
  logic [63:0] ex_rs;
  logic [63:0] ex_rt;
  logic [9:0]  ex_target;
  logic        ex_kill;
  logic        branch;
  logic [1:0]  br_tid;
  logic [9:0]  br_addr;
  logic [15:0] br_count;

  branch_unit_4way #(.ADDR_W(10), .DATA_W(64), .SQUASH_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .ex_valid(ex_valid), .ex_tid(ex_tid),
    .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_target(ex_target),
    .ex_kill(ex_kill), .branch(branch), .br_tid(br_tid), .br_addr(br_addr),
    .br_count(br_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        valid;
    logic [1:0]  tid;
    logic [2:0]  op;
    logic [63:0] rs;
    logic [63:0] rt;
    logic [9:0]  tgt;
    logic        exp_kill;
    logic        exp_branch;
    logic [9:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic        branch;
    logic [1:0]  tid;
    logic [9:0]  addr;
    logic [15:0] count;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  int          m_sq [4];
  logic        m_branch;
  logic [1:0]  m_tid;
  logic [9:0]  m_addr;
  logic [15:0] m_count;

  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] JRV  = 64'hFFFF_FFFF_FFFF_F3A5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_sq[t] = 0;
    m_branch = 1'b0;
    m_tid    = 2'd0;
    m_addr   = 10'd0;
    m_count  = 16'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    en        = 1'($urandom);
    ex_valid  = 1'($urandom);
    ex_tid    = 2'($urandom);
    ex_op     = 3'($urandom);
    ex_rs     = {$urandom, $urandom};
    ex_rt     = {$urandom, $urandom};
    ex_target = 10'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_branch", {63'd0, branch}, 64'd0);
    chk("rst_br_tid", {62'd0, br_tid}, 64'd0);
    chk("rst_br_addr", {54'd0, br_addr}, 64'd0);
    chk("rst_br_count", {48'd0, br_count}, 64'd0);
    for (int t = 0; t < 4; t++) begin
      ex_valid = 1'b1;
      ex_tid   = 2'(t);
      #1;
      chk("rst_ex_kill", {63'd0, ex_kill}, 64'd0);
    end
    rst      = 1'b0;
    en       = 1'b0;
    ex_valid = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  // Drive one cycle, check combinational kill, predict and score registers.
  task automatic apply(input vec_t v, input string name);
    logic   k, tk;
    logic [9:0] tg;
    exp_t   e, got;
    @(negedge clk);
    en = v.en; ex_valid = v.valid; ex_tid = v.tid; ex_op = v.op;
    ex_rs = v.rs; ex_rt = v.rt; ex_target = v.tgt;
    #1;
    k  = v.valid && (m_sq[v.tid] != 0);
    tk = 1'b0;
    tg = v.tgt;
    if (v.valid && !k) begin
      case (v.op)
        3'd0: tk = (v.rs == v.rt);
        3'd1: tk = (v.rs != v.rt);
        3'd2: tk = ($signed(v.rs) <  $signed(v.rt));
        3'd3: tk = ($signed(v.rs) >= $signed(v.rt));
        3'd4: tk = 1'b1;
        3'd5: begin tk = 1'b1; tg = v.rs[9:0]; end
        default: tk = 1'b0;
      endcase
    end
    chk({name, "_kill_tbl"}, {63'd0, ex_kill}, {63'd0, v.exp_kill});
    chk({name, "_kill_mdl"}, {63'd0, ex_kill}, {63'd0, k});
    if (v.en) begin
      m_branch = tk;
      if (tk) begin
        m_tid   = v.tid;
        m_addr  = tg;
        m_count = m_count + 16'd1;
        m_sq[v.tid] = 3;
      end else if (k) begin
        m_sq[v.tid] = m_sq[v.tid] - 1;
      end
    end
    e.branch = m_branch; e.tid = m_tid; e.addr = m_addr; e.count = m_count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      chk({name, "_branch"}, {63'd0, branch}, {63'd0, got.branch});
      chk({name, "_br_tid"}, {62'd0, br_tid}, {62'd0, got.tid});
      chk({name, "_br_addr"}, {54'd0, br_addr}, {54'd0, got.addr});
      chk({name, "_br_count"}, {48'd0, br_count}, {48'd0, got.count});
    end
    chk({name, "_branch_tbl"}, {63'd0, branch}, {63'd0, v.exp_branch});
    chk({name, "_addr_tbl"}, {54'd0, br_addr}, {54'd0, v.exp_addr});
  endtask

  vec_t tbl_a [17];
  vec_t tbl_b [6];
  vec_t tbl_c [4];

  initial begin
    rst = 1'b1; en = 1'b0; ex_valid = 1'b0; ex_tid = 2'd0; ex_op = 3'd6;
    ex_rs = 64'd0; ex_rt = 64'd0; ex_target = 10'd0;

    // en, valid, tid, op, rs, rt, tgt, exp_kill, exp_branch, exp_addr
    tbl_a[0]  = '{1'b1, 1'b1, 2'd2, 3'd0, 64'd5, 64'd5, 10'h120, 1'b0, 1'b1, 10'h120};
    tbl_a[1]  = '{1'b1, 1'b1, 2'd2, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h120};
    tbl_a[2]  = '{1'b1, 1'b1, 2'd0, 3'd6, 64'd0, 64'd0, 10'h000, 1'b0, 1'b0, 10'h120};
    tbl_a[3]  = '{1'b1, 1'b1, 2'd1, 3'd6, 64'd0, 64'd0, 10'h000, 1'b0, 1'b0, 10'h120};
    tbl_a[4]  = '{1'b1, 1'b1, 2'd3, 3'd6, 64'd0, 64'd0, 10'h000, 1'b0, 1'b0, 10'h120};
    tbl_a[5]  = '{1'b1, 1'b1, 2'd2, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h120};
    tbl_a[6]  = '{1'b1, 1'b1, 2'd2, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h120};
    tbl_a[7]  = '{1'b1, 1'b1, 2'd2, 3'd6, 64'd0, 64'd0, 10'h000, 1'b0, 1'b0, 10'h120};
    tbl_a[8]  = '{1'b1, 1'b1, 2'd0, 3'd2, NEG1,  64'd1, 10'h055, 1'b0, 1'b1, 10'h055};
    tbl_a[9]  = '{1'b1, 1'b1, 2'd1, 3'd3, NEG1,  64'd1, 10'h077, 1'b0, 1'b0, 10'h055};
    tbl_a[10] = '{1'b1, 1'b1, 2'd1, 3'd2, 64'd5, NEG3,  10'h066, 1'b0, 1'b0, 10'h055};
    tbl_a[11] = '{1'b1, 1'b1, 2'd1, 3'd1, 64'd1, 64'd2, 10'h0AA, 1'b0, 1'b1, 10'h0AA};
    tbl_a[12] = '{1'b1, 1'b1, 2'd1, 3'd7, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h0AA};
    tbl_a[13] = '{1'b1, 1'b1, 2'd1, 3'd4, 64'd0, 64'd0, 10'h3FF, 1'b1, 1'b0, 10'h0AA};
    tbl_a[14] = '{1'b1, 1'b1, 2'd3, 3'd0, 64'd1, 64'd2, 10'h0BB, 1'b0, 1'b0, 10'h0AA};
    tbl_a[15] = '{1'b1, 1'b1, 2'd3, 3'd3, 64'd7, 64'd7, 10'h011, 1'b0, 1'b1, 10'h011};
    tbl_a[16] = '{1'b1, 1'b0, 2'd3, 3'd4, 64'd0, 64'd0, 10'h222, 1'b0, 1'b0, 10'h011};

    tbl_b[0]  = '{1'b1, 1'b1, 2'd3, 3'd5, JRV,   64'd0, 10'h000, 1'b0, 1'b1, 10'h3A5};
    tbl_b[1]  = '{1'b0, 1'b1, 2'd0, 3'd4, 64'd0, 64'd0, 10'h100, 1'b0, 1'b1, 10'h3A5};
    tbl_b[2]  = '{1'b0, 1'b1, 2'd3, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b1, 10'h3A5};
    tbl_b[3]  = '{1'b0, 1'b0, 2'd0, 3'd0, 64'd0, 64'd0, 10'h000, 1'b0, 1'b1, 10'h3A5};
    tbl_b[4]  = '{1'b1, 1'b1, 2'd0, 3'd6, 64'd0, 64'd0, 10'h000, 1'b0, 1'b0, 10'h3A5};
    tbl_b[5]  = '{1'b1, 1'b1, 2'd3, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h3A5};

    tbl_c[0]  = '{1'b1, 1'b1, 2'd0, 3'd4, 64'd0, 64'd0, 10'h200, 1'b0, 1'b1, 10'h200};
    tbl_c[1]  = '{1'b1, 1'b1, 2'd1, 3'd4, 64'd0, 64'd0, 10'h201, 1'b0, 1'b1, 10'h201};
    tbl_c[2]  = '{1'b1, 1'b1, 2'd0, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h201};
    tbl_c[3]  = '{1'b1, 1'b1, 2'd1, 3'd6, 64'd0, 64'd0, 10'h000, 1'b1, 1'b0, 10'h201};

    model_reset();
    do_reset();
    for (int i = 0; i < 17; i++) apply(tbl_a[i], $sformatf("a%0d", i));
    chk("a_final_tid", {62'd0, br_tid}, 64'd3);
    chk("a_final_count", {48'd0, br_count}, 64'd4);

    // Mid-operation reset: pending kills on threads 0, 1 and 3 are cleared.
    do_reset();
    for (int i = 0; i < 6; i++) apply(tbl_b[i], $sformatf("b%0d", i));

    // Counter wrap: preload the count to 0xFFFF, then two back-to-back jumps.
    do_reset();
    @(negedge clk);
    force dut.br_count_q = 16'hFFFF;
    #1;
    release dut.br_count_q;
    m_count = 16'hFFFF;
    #1;
    chk("wrap_preload", {48'd0, br_count}, 64'h0000_0000_0000_FFFF);
    apply(tbl_c[0], "c0");
    chk("wrap_zero", {48'd0, br_count}, 64'd0);
    chk("wrap_tid0", {62'd0, br_tid}, 64'd0);
    apply(tbl_c[1], "c1");
    chk("b2b_tid1", {62'd0, br_tid}, 64'd1);
    chk("b2b_count", {48'd0, br_count}, 64'd1);
    for (int i = 2; i < 4; i++) apply(tbl_c[i], $sformatf("c%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
